// File: rtl/decode_execute_unit_if.sv
// decode_execute_unit_if: instruction/operand inputs and decoded/executed outputs of the decode-execute stage
interface decode_execute_unit_if;
  logic [31:0] instruction;
  logic [63:0] rs1_data, rs2_data;
  logic [63:0] pc, immediate, alu_output, store_data, next_pc;
  logic [4:0]  rs1, rs2, write_addr;
  logic        ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch;
  logic [3:0]  alu_control_signal;
  logic        zero, invOp, invFunc;
  modport master (
    output instruction, rs1_data, rs2_data,
    input  pc, rs1, rs2, write_addr, ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch,
           alu_control_signal, immediate, alu_output, zero, store_data, next_pc, invOp, invFunc
  );
  modport slave (
    input  instruction, rs1_data, rs2_data,
    output pc, rs1, rs2, write_addr, ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch,
           alu_control_signal, immediate, alu_output, zero, store_data, next_pc, invOp, invFunc
  );
endinterface

// File: rtl/decode_execute_unit.sv
// decode_execute_unit: combinational RV64 subset decode, ALU and next-PC logic around a single PC register
module decode_execute_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic clock,
  input logic reset,
  decode_execute_unit_if.slave bus
);
  logic [31:0] ins;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [63:0] pc_q, imm, op_b, alu, nxt;
  logic [63:0] i_imm, s_imm, b_imm;
  logic [3:0]  ctl;
  logic        alu_src, reg_write, mem_read, mem_to_reg, mem_write, branch, inv_op, inv_func, zero;
  assign ins    = bus.instruction;
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign i_imm  = {{52{ins[31]}}, ins[31:20]};
  assign s_imm  = {{52{ins[31]}}, ins[31:25], ins[11:7]};
  assign b_imm  = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  // Invalid encodings fall through with all defaults: no enables, ADD, rs2 operand, zero immediate
  always_comb begin
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    inv_op     = 1'b0;
    inv_func   = 1'b0;
    ctl        = 4'b0010;
    imm        = 64'h0;
    case (opcode)
      7'b0110011: begin
        if ({f7, f3} == 10'b0000000_000) ctl = 4'b0010;
        else if ({f7, f3} == 10'b0100000_000) ctl = 4'b0110;
        else if ({f7, f3} == 10'b0000000_111) ctl = 4'b0000;
        else if ({f7, f3} == 10'b0000000_110) ctl = 4'b0001;
        else inv_func = 1'b1;
        reg_write = !inv_func;
      end
      7'b0010011: begin
        inv_func  = f3 != 3'b000;
        reg_write = !inv_func;
        alu_src   = !inv_func;
        imm       = inv_func ? 64'h0 : i_imm;
      end
      7'b0000011: begin
        inv_func   = f3 != 3'b011;
        reg_write  = !inv_func;
        alu_src    = !inv_func;
        mem_read   = !inv_func;
        mem_to_reg = !inv_func;
        imm        = inv_func ? 64'h0 : i_imm;
      end
      7'b0100011: begin
        inv_func  = f3 != 3'b011;
        mem_write = !inv_func;
        alu_src   = !inv_func;
        imm       = inv_func ? 64'h0 : s_imm;
      end
      7'b1100011: begin
        inv_func = f3 != 3'b000;
        branch   = !inv_func;
        ctl      = inv_func ? 4'b0010 : 4'b0110;
        imm      = inv_func ? 64'h0 : b_imm;
      end
      default: inv_op = 1'b1;
    endcase
  end
  assign op_b = alu_src ? imm : bus.rs2_data;
  assign alu  = ctl == 4'b0000 ? (bus.rs1_data & op_b) :
                ctl == 4'b0001 ? (bus.rs1_data | op_b) :
                ctl == 4'b0010 ? (bus.rs1_data + op_b) :
                ctl == 4'b0110 ? (bus.rs1_data - op_b) : 64'h0;
  assign zero = alu == 64'h0;
  assign nxt  = (branch && zero) ? pc_q + imm : pc_q + 64'd4;
  always_ff @(posedge clock or negedge reset)
    if (!reset) pc_q <= RESET_PC;
    else pc_q <= nxt;
  assign bus.pc                 = pc_q;
  assign bus.rs1                = ins[19:15];
  assign bus.rs2                = ins[24:20];
  assign bus.write_addr         = ins[11:7];
  assign bus.ALUSrc             = alu_src;
  assign bus.RegWrite           = reg_write && (ins[11:7] != 5'd0);
  assign bus.MemRead            = mem_read;
  assign bus.MemtoReg           = mem_to_reg;
  assign bus.MemWrite           = mem_write;
  assign bus.Branch             = branch;
  assign bus.alu_control_signal = ctl;
  assign bus.immediate          = imm;
  assign bus.alu_output         = alu;
  assign bus.zero               = zero;
  assign bus.store_data         = bus.rs2_data;
  assign bus.next_pc            = nxt;
  assign bus.invOp              = inv_op;
  assign bus.invFunc            = inv_func;
endmodule

// File: tb/tb_decode_execute_unit.sv
// tb_decode_execute_unit: directed vectors pushed into a scoreboard queue, checked by a negedge monitor
module tb_decode_execute_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clock = ~clock;
  decode_execute_unit_if bus ();
  decode_execute_unit #(.RESET_PC(64'h0)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic [63:0] pc, imm, alu, nxt, store;
    logic [8:0]  ctrl;
    logic [3:0]  ctl;
    logic [14:0] regs;
  } exp_t;
  exp_t q[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // ctrl = {ALUSrc, RegWrite, MemRead, MemtoReg, MemWrite, Branch, invOp, invFunc, zero}
  task automatic vec(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] epc, input logic [8:0] ectrl, input logic [3:0] ectl,
                     input logic [63:0] eimm, input logic [63:0] ealu, input logic [63:0] enxt,
                     input logic [14:0] eregs);
    exp_t e;
    @(posedge clock);
    #1;
    bus.instruction = ins;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    e.pc = epc; e.imm = eimm; e.alu = ealu; e.nxt = enxt; e.store = b;
    e.ctrl = ectrl; e.ctl = ectl; e.regs = eregs;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pc", bus.pc, e.pc);
        check("ctrl", {55'h0, bus.ALUSrc, bus.RegWrite, bus.MemRead, bus.MemtoReg, bus.MemWrite,
                       bus.Branch, bus.invOp, bus.invFunc, bus.zero}, {55'h0, e.ctrl});
        check("alu_control", {60'h0, bus.alu_control_signal}, {60'h0, e.ctl});
        check("immediate", bus.immediate, e.imm);
        check("alu_output", bus.alu_output, e.alu);
        check("next_pc", bus.next_pc, e.nxt);
        check("store_data", bus.store_data, e.store);
        check("regs", {49'h0, bus.rs1, bus.rs2, bus.write_addr}, {49'h0, e.regs});
      end
    end
  end
  initial begin
    bus.instruction = 32'h0;
    bus.rs1_data    = 64'h0;
    bus.rs2_data    = 64'h0;
    // held in reset across a clock edge: pc stays at RESET_PC
    vec(32'h00B500B3, 64'd10, 64'd11, 64'h0, 9'b010000000, 4'b0010, 64'h0, 64'd21, 64'h4, {5'd10, 5'd11, 5'd1});
    @(negedge clock);
    #1 reset = 1'b1;
    vec(32'hFFF28293, 64'd5, 64'd0, 64'h4, 9'b110000000, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 64'h8, {5'd5, 5'd31, 5'd5});
    vec(32'h00C53423, 64'd10, 64'd12, 64'h8, 9'b100010000, 4'b0010, 64'd8, 64'd18, 64'hC, {5'd10, 5'd12, 5'd8});
    vec(32'hFFFFFFFF, 64'd3, 64'd4, 64'hC, 9'b000000100, 4'b0010, 64'h0, 64'd7, 64'h10, {5'd31, 5'd31, 5'd31});
    vec(32'h02B500B3, 64'd10, 64'd11, 64'h10, 9'b000000010, 4'b0010, 64'h0, 64'd21, 64'h14, {5'd10, 5'd11, 5'd1});
    vec(32'h40B500B3, 64'd10, 64'd11, 64'h14, 9'b010000000, 4'b0110, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h18, {5'd10, 5'd11, 5'd1});
    vec(32'h00B570B3, 64'hF0F0, 64'hFF00, 64'h18, 9'b010000000, 4'b0000, 64'h0, 64'hF000, 64'h1C, {5'd10, 5'd11, 5'd1});
    vec(32'h00B560B3, 64'hF0, 64'h0F, 64'h1C, 9'b010000000, 4'b0001, 64'h0, 64'hFF, 64'h20, {5'd10, 5'd11, 5'd1});
    vec(32'h00A50863, 64'd10, 64'd10, 64'h20, 9'b000001001, 4'b0110, 64'd16, 64'h0, 64'h30, {5'd10, 5'd10, 5'd16});
    vec(32'h00A50863, 64'd10, 64'd11, 64'h30, 9'b000001000, 4'b0110, 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'h34, {5'd10, 5'd10, 5'd16});
    vec(32'h00B50033, 64'd10, 64'd11, 64'h34, 9'b000000000, 4'b0010, 64'h0, 64'd21, 64'h38, {5'd10, 5'd11, 5'd0});
    vec(32'h00853283, 64'd100, 64'd0, 64'h38, 9'b111100000, 4'b0010, 64'd8, 64'd108, 64'h3C, {5'd10, 5'd8, 5'd5});
    vec(32'h00151513, 64'd2, 64'd3, 64'h3C, 9'b000000010, 4'b0010, 64'h0, 64'd5, 64'h40, {5'd10, 5'd1, 5'd10});
    vec(32'h00B500B3, 64'd10, 64'd11, 64'h40, 9'b010000000, 4'b0010, 64'h0, 64'd21, 64'h44, {5'd10, 5'd11, 5'd1});
    @(negedge clock);
    #1 reset = 1'b0;
    #1 check("async_reset_pc", bus.pc, 64'h0);
    vec(32'h00B500B3, 64'd10, 64'd11, 64'h0, 9'b010000000, 4'b0010, 64'h0, 64'd21, 64'h4, {5'd10, 5'd11, 5'd1});
    @(negedge clock);
    #1 reset = 1'b1;
    vec(32'hFFF28293, 64'd5, 64'd0, 64'h4, 9'b110000000, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 64'h8, {5'd5, 5'd31, 5'd5});
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
